iter_mul64: RTL

- Multi-cycle 64x64 shift-and-add multiplier for the datapath's MUL instruction. Produces the low 64 bits of the product.
- Sits directly downstream of the team's 64-bit ripple adder (Big64full_adder) and consumes its sum output once per cycle to accumulate partial products.
- Exposes a start/done handshake to the control unit, plus zero/negative flags for the flag register.

---
 rtl/mul_pkg.sv | 13 +
 rtl/Big64full_adder.sv | 21 ++
 rtl/iter_mul64.sv | 111 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative 64x64 multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MUL_ITERS = 64;
  localparam int CNT_W     = 7;

endpackage

// File: rtl/Big64full_adder.sv
// 64-bit ripple-carry adder; the carry out of bit 63 is not exposed since
// its only consumer truncates to 64 bits.
module Big64full_adder (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        cin_i,
  output logic [63:0] sum_o
);

  // Ripple the carry bit by bit from the LSB.
  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = 64'd0;
    for (int i = 0; i < 64; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/iter_mul64.sv
// Multi-cycle shift-and-add multiplier producing the low 64 bits of a*b,
// with start/done handshake and zero/negative flags on the result.
module iter_mul64
  import mul_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        zero,
  output logic        negative
);

  state_e             state_q, state_d;
  logic [63:0]        acc_q, acc_d;
  logic [63:0]        mcand_q, mcand_d;
  logic [63:0]        mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        product_q;
  logic               zero_q;
  logic               negative_q;
  logic [63:0]        sum_s;
  logic               load_s;

  Big64full_adder u_adder (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .cin_i (1'b0),
    .sum_o (sum_s)
  );

  // Next-state and datapath update for one shift-and-add step.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = 64'd0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = (EARLY_EXIT && (b == 64'd0)) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = sum_s;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if ((cnt_q == CNT_W'(MUL_ITERS - 1)) || (EARLY_EXIT && (mplier_d == 64'd0))) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result is captured on the transition into DONE, including the final add.
  assign load_s = (state_d == DONE) && (state_q != DONE);

  // State, datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= 64'd0;
      mcand_q    <= 64'd0;
      mplier_q   <= 64'd0;
      cnt_q      <= {CNT_W{1'b0}};
      product_q  <= 64'd0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      if (load_s) begin
        product_q  <= acc_d;
        zero_q     <= (acc_d == 64'd0);
        negative_q <= acc_d[63];
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign product  = product_q;
  assign zero     = zero_q;
  assign negative = negative_q;

endmodule
